alu_muldiv: RTL
===============

// Module: alu_muldiv
// PURPOSE
//  Parametrised successor ALU for the MIPS datapath. It keeps the single-cycle logic/arith/shift ops.
//  It adds an iterative signed/unsigned multiply/divide engine that owns the HI/LO registers.
//  A busy/stall handshake lets the control unit hold the pipeline until HI/LO are valid.
//  Sits between the register-file read ports and the EX/MEM result mux.
// PARAMETERS
//  WIDTH  32  datapath width; even, >=8
//  BPC    1   mul/div bits retired per cycle; 1, 2 or 4; must divide WIDTH
//  OP_W   5   ALUop width
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  reg1        in   WIDTH  operand A (rs)
//  reg2        in   WIDTH  operand B (rt / immediate / shamt)
//  ALUop       in   OP_W   operation select
//  op_valid    in   1      ALUop/operands are a real instruction this cycle
//  ALUresult   out  WIDTH  combinational result
//  wr_en       out  1      result should be written back (0 for MOVZ miss, mul/div, MTHI/MTLO)
//  stall       out  1      hold the pipeline; current op cannot complete this cycle
//  busy        out  1      mul/div engine running
//  done        out  1      one-cycle pulse: HI/LO updated this edge
//  div_zero    out  1      qualifies done: divisor was zero
// BEHAVIOUR
//  Opcodes: AND 00000, OR 00001, ADD 00010, LUI 00011, MFLO 00100, MFHI 00101, SUB 00110,
//   SLT 00111 (signed), SLL 01000, SRA 01001 (arithmetic), DIV 01010, DIVU 01011, MULT 01100,
//   MOVZ 01101, MULTU 01110, MTHI 01111, MTLO 10000. Others: ALUresult=0, wr_en=0.
//  Single-cycle ops: combinational, zero latency; ADD/SUB wrap modulo 2^WIDTH, no trap.
//   Shift amount = reg2[$clog2(WIDTH)-1:0]. LUI = {reg2[WIDTH/2-1:0], WIDTH/2 zeros}.
//   MOVZ: ALUresult=reg1 always; wr_en = (reg2==0). No latches on any path.
//  Reset (async, rst_n=0): HI=LO=0, state IDLE, busy=done=div_zero=0; mid-op aborts, no done.
//  FSM IDLE -> RUN -> IDLE:
//   IDLE: op_valid & mul/div op -> capture operands (magnitudes and sign flags for signed ops);
//     load counter = WIDTH/BPC; go to RUN. busy=1 from the next cycle.
//   RUN: BPC shift-add (mul) or restoring-subtract (div) steps per cycle; counter decrements.
//     When counter reaches 1: write HI/LO, pulse done, return to IDLE. Latency = WIDTH/BPC cycles.
//   MULT/MULTU: {HI,LO} = 2*WIDTH-bit product; signed result = negated magnitude if signs differ.
//   DIV/DIVU: LO=quotient, HI=remainder. Signed: quotient negative if signs differ; remainder
//     takes the dividend's sign. MIN/-1 -> LO=MIN, HI=0.
//   Divisor 0: skip iteration, done+div_zero next cycle, HI=reg1, LO=all ones.
//  stall = op_valid & busy & ALUop in {MFHI, MFLO, MTHI, MTLO, DIV, DIVU, MULT, MULTU}.
//   Other ops proceed while busy. A new mul/div is accepted only in IDLE; the accept edge is
//   the first cycle stall drops. On the done cycle MFHI/MFLO return the new value (bypass).
//  MTHI/MTLO (IDLE only): HI/LO <= reg1 at the edge.
//   MFHI/MFLO: ALUresult = HI/LO, wr_en=1 when not stalled.
//  done/div_zero low except for the single completion cycle.
// TESTING
//  1 Reset: rst_n low mid-DIV -> busy=0, HI=LO=0, no done pulse; MFLO returns 0.
//  2 MULT 0xFFFFFFFE x 3 (WIDTH=32, BPC=1) -> done exactly 32 cycles after accept;
//    HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//  3 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> div_zero=1, HI=7, LO=0xFFFFFFFF.
//  4 MFHI issued 3 cycles after DIV accept -> stall high until done; value = new HI;
//    ADD 5+6 during busy -> 11, no stall.
//  5 SRA 0x80000000 by 4 -> 0xF8000000; SLT -1<1 -> 1; MOVZ reg2=1 -> wr_en=0.
//  6 BPC=4 and WIDTH=16 build: random MULT/DIV/DIVU/MULTU vs reference model;
//    latency = 4 cycles each.

Source files
------------

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_if
//  Brief    : Operand/opcode and result/handshake bundle between the control
//             unit, register-file read ports and the ALU with mul/div engine.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5
);
    logic [WIDTH-1:0] reg1;
    logic [WIDTH-1:0] reg2;
    logic [OP_W-1:0]  ALUop;
    logic             op_valid;
    logic [WIDTH-1:0] ALUresult;
    logic             wr_en;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output reg1, reg2, ALUop, op_valid,
        input  ALUresult, wr_en, stall, busy, done, div_zero
    );

    modport slave (
        input  reg1, reg2, ALUop, op_valid,
        output ALUresult, wr_en, stall, busy, done, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv
//  Brief    : Single-cycle MIPS ALU plus an iterative signed/unsigned
//             multiply/divide engine owning HI/LO, with busy/stall handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1,
    parameter int OP_W  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_muldiv_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [OP_W-1:0] OP_AND   = OP_W'(5'h00);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(5'h01);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(5'h02);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(5'h03);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(5'h04);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5'h05);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'h06);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5'h07);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5'h08);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(5'h09);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(5'h0A);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(5'h0B);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(5'h0C);
    localparam logic [OP_W-1:0] OP_MOVZ  = OP_W'(5'h0D);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(5'h0E);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(5'h0F);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5'h10);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic                 w_op_md, w_op_div, w_op_signed, w_op_hilo;
    logic                 w_busy, w_stall;
    logic                 w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag;
    logic [SH_W-1:0]      w_shamt;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic [WIDTH:0]       w_rem_sh, w_diff, w_sum;
    logic [2*WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]     w_quo, w_rem;
    logic [WIDTH-1:0]     w_res;
    logic                 w_wr;

    assign w_op_div    = (bus.ALUop == OP_DIV) || (bus.ALUop == OP_DIVU);
    assign w_op_md     = w_op_div || (bus.ALUop == OP_MULT) || (bus.ALUop == OP_MULTU);
    assign w_op_signed = (bus.ALUop == OP_DIV) || (bus.ALUop == OP_MULT);
    assign w_op_hilo   = (bus.ALUop == OP_MFHI) || (bus.ALUop == OP_MFLO) ||
                         (bus.ALUop == OP_MTHI) || (bus.ALUop == OP_MTLO);

    assign w_busy  = (state_q == ST_RUN);
    assign w_stall = bus.op_valid && w_busy && (w_op_md || w_op_hilo);

    assign w_a_neg = w_op_signed && bus.reg1[WIDTH-1];
    assign w_b_neg = w_op_signed && bus.reg2[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.reg1 : bus.reg1;
    assign w_b_mag = w_b_neg ? -bus.reg2 : bus.reg2;
    assign w_shamt = bus.reg2[SH_W-1:0];

    // acc holds {partial, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        w_acc_step = acc_q;
        w_rem_sh   = '0;
        w_diff     = '0;
        w_sum      = '0;
        for (int i = 0; i < BPC; i++) begin
            if (is_div_q) begin
                w_rem_sh = {w_acc_step[2*WIDTH-1:WIDTH], w_acc_step[WIDTH-1]};
                w_diff   = w_rem_sh - {1'b0, dvs_q};
                if (!w_diff[WIDTH]) begin
                    w_acc_step = {w_diff[WIDTH-1:0], w_acc_step[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc_step = {w_rem_sh[WIDTH-1:0], w_acc_step[WIDTH-2:0], 1'b0};
                end
            end else begin
                w_sum      = {1'b0, w_acc_step[2*WIDTH-1:WIDTH]} +
                             (w_acc_step[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
                w_acc_step = {w_sum, w_acc_step[WIDTH-1:1]};
            end
        end
    end

    assign w_mul_res = neg_q     ? -w_acc_step                     : w_acc_step;
    assign w_quo     = neg_q     ? -w_acc_step[WIDTH-1:0]          : w_acc_step[WIDTH-1:0];
    assign w_rem     = rem_neg_q ? -w_acc_step[2*WIDTH-1:WIDTH]    : w_acc_step[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dvs_d      = dvs_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid && w_op_md) begin
                    if (w_op_div && (bus.reg2 == '0)) begin
                        // No iteration: results land at the accept edge
                        hi_d       = bus.reg1;
                        lo_d       = '1;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                        cnt_d     = CNT_W'(STEPS);
                        acc_d     = {{WIDTH{1'b0}}, w_a_mag};
                        dvs_d     = w_b_mag;
                        is_div_d  = w_op_div;
                        neg_d     = w_a_neg ^ w_b_neg;
                        rem_neg_d = w_a_neg;
                    end
                end else if (bus.op_valid && (bus.ALUop == OP_MTHI)) begin
                    hi_d = bus.reg1;
                end else if (bus.op_valid && (bus.ALUop == OP_MTLO)) begin
                    lo_d = bus.reg1;
                end
            end
            ST_RUN: begin
                acc_d = w_acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        hi_d = w_rem;
                        lo_d = w_quo;
                    end else begin
                        hi_d = w_mul_res[2*WIDTH-1:WIDTH];
                        lo_d = w_mul_res[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            dvs_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dvs_q      <= dvs_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        w_res = '0;
        w_wr  = 1'b1;
        case (bus.ALUop)
            OP_AND:  w_res = bus.reg1 & bus.reg2;
            OP_OR:   w_res = bus.reg1 | bus.reg2;
            OP_ADD:  w_res = bus.reg1 + bus.reg2;
            OP_LUI:  w_res = {bus.reg2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFLO: begin w_res = lo_q; w_wr = !w_stall; end
            OP_MFHI: begin w_res = hi_q; w_wr = !w_stall; end
            OP_SUB:  w_res = bus.reg1 - bus.reg2;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.reg1) < $signed(bus.reg2))};
            OP_SLL:  w_res = bus.reg1 << w_shamt;
            OP_SRA:  w_res = $unsigned($signed(bus.reg1) >>> w_shamt);
            OP_MOVZ: begin w_res = bus.reg1; w_wr = (bus.reg2 == '0); end
            default: w_wr = 1'b0;
        endcase
    end

    assign bus.ALUresult = w_res;
    assign bus.wr_en     = w_wr;
    assign bus.stall     = w_stall;
    assign bus.busy      = w_busy;
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
endmodule
`default_nettype wire
